// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller.
//   scan_state_e : scan FSM states (IDLE, SHOW, BLANK)
//   DARK_CODE    : character code that decodes to all segments dark
//   cnt_w()      : width of a down-counter able to hold max(a, b)
package seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    localparam logic [2:0] DARK_CODE = 3'd0;

    function automatic int cnt_w(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Digit-buffer write bus of seg_scan_ctrl.
//   wr_en   : write strobe
//   wr_addr : digit position to write (out-of-range positions are dropped)
//   wr_data : character code for that position
// master drives the bus, slave (the scan controller) receives it.
interface seg_scan_ctrl_if;

    logic       wr_en;
    logic [2:0] wr_addr;
    logic [2:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);

endinterface

// File: rtl/seg_scan_ctrl_scan_timer.sv
// scan_timer: loadable down-counter with terminal-count flag.
// Shared by the SHOW and BLANK intervals of the scan FSM.
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   load     : load load_val this clock (wins over counting)
//   load_val : value to load; the interval lasts load_val+1 clocks
//   tc       : high while the count is zero; the count holds at zero
module scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for N_DIGITS seven-segment
// digits. Holds a per-digit character buffer and cycles SHOW/BLANK per digit;
// the segment decoder is external and registered, so digit_sel lags by one.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   enable      : scan enable (level); low forces IDLE with outputs dark
//   scroll_en   : (SEG_SCROLL_EN only) advance the display offset per frame
//   wr          : digit-buffer write bus (seg_scan_ctrl_if.slave)
//   seg_number  : character code for the decoder (0 = dark)
//   digit_sel   : active-low digit enables, at most one low
//   frame_done  : one-clock pulse when the scan wraps back to digit 0
// Build option: define SEG_SCROLL_EN to add the scroll_en port and offset.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS   = 8,
    parameter int SHOW_CLKS  = 50000,
    parameter int BLANK_CLKS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
`ifdef SEG_SCROLL_EN
    input  logic                scroll_en,
`endif
    seg_scan_ctrl_if.slave      wr,
    output logic [2:0]          seg_number,
    output logic [N_DIGITS-1:0] digit_sel,
    output logic                frame_done
);

    localparam int IW = $clog2(N_DIGITS);
    localparam int CW = cnt_w(SHOW_CLKS, BLANK_CLKS);
    localparam logic [CW-1:0] SHOW_LD  = CW'(SHOW_CLKS - 1);
    localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CLKS - 1);

    scan_state_e                    state_q, state_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic [N_DIGITS-1:0][2:0]       buf_q, buf_d;
    logic [2:0]                     seg_q, seg_d;
    logic [N_DIGITS-1:0]            digit_sel_q, digit_sel_d;
    logic                           frame_done_q, frame_done_d;
    logic [2:0]                     off_d;
`ifdef SEG_SCROLL_EN
    logic [2:0]                     off_q;
`endif
    logic [IW:0]                    pos;
    logic                           tmr_load, tmr_tc;
    logic [CW-1:0]                  tmr_val;

    scan_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        buf_d        = buf_q;
        digit_sel_d  = '1;
        frame_done_d = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;

        // Buffer writes are independent of the FSM and never stall it.
        if (wr.wr_en && ({1'b0, wr.wr_addr} < 4'(N_DIGITS)))
            buf_d[wr.wr_addr[IW-1:0]] = wr.wr_data;

        if (!enable) begin
            state_d  = IDLE;
            idx_d    = '0;
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = SHOW;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = SHOW_LD;
                end
                SHOW: begin
                    // Decoder register adds a clock, so the digit is lit one
                    // clock behind the SHOW state (including its last clock).
                    digit_sel_d[idx_q] = 1'b0;
                    if (tmr_tc) begin
                        state_d  = BLANK;
                        tmr_load = 1'b1;
                        tmr_val  = BLANK_LD;
                    end
                end
                BLANK: begin
                    if (tmr_tc) begin
                        state_d  = SHOW;
                        tmr_load = 1'b1;
                        tmr_val  = SHOW_LD;
                        if (idx_q == IW'(N_DIGITS - 1)) begin
                            idx_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef SEG_SCROLL_EN
        // Offset advances together with the wrap so the new frame already
        // starts at the rotated position.
        off_d = off_q;
        if (frame_done_d && scroll_en)
            off_d = (off_q == 3'(N_DIGITS - 1)) ? 3'd0 : off_q + 3'd1;
`else
        off_d = 3'd0;
`endif

        // Output is computed from next-state so seg_number tracks the state
        // and buffer of the same clock (a write to the shown digit appears
        // on the very next clock).
        pos = (IW+1)'(idx_d) + (IW+1)'(off_d);
        if (pos >= (IW+1)'(N_DIGITS))
            pos = pos - (IW+1)'(N_DIGITS);
        seg_d = (state_d == SHOW) ? buf_d[pos[IW-1:0]] : DARK_CODE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            buf_q        <= '0;
            seg_q        <= DARK_CODE;
            digit_sel_q  <= '1;
            frame_done_q <= 1'b0;
`ifdef SEG_SCROLL_EN
            off_q        <= 3'd0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            buf_q        <= buf_d;
            seg_q        <= seg_d;
            digit_sel_q  <= digit_sel_d;
            frame_done_q <= frame_done_d;
`ifdef SEG_SCROLL_EN
            off_q        <= off_d;
`endif
        end
    end

    assign seg_number = seg_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;

endmodule
